qcore_fwd_scoreboard: RTL and testbench
=======================================

QCORE_FWD_SCOREBOARD -- requirements
Module: qcore_fwd_scoreboard

Interface
REQ-001 SHALL have parameter NPORT, default 2: number of register read ports.
REQ-002 SHALL have parameter NSTG, default 3: number of forwarding stages; index 0 is the youngest stage, NSTG-1 is the write-back stage.
REQ-003 SHALL have parameter AW, default 7: register address width.
REQ-004 SHALL have parameter DW, default 32: data width.
REQ-005 SHALL have parameter LD_STG, default 1: first stage index at which DMEM data is valid.
REQ-006 SHALL have parameter LDQ, default 4: outstanding-load queue depth, a power of 2, at least 2.
REQ-007 SHALL have ports as follows (name, direction, width, meaning):
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- halt_i  in  1  freeze all state and outputs.
- flush_i  in  1  discard the load queue and all pending bits.
- rs_re_i  in  NPORT  read-port enable.
- rs_addr_i  in  NPORT x AW  read address.
- rs_dt_i  in  NPORT x DW  register-file data.
- stg_we_i  in  NSTG  stage will write a register.
- stg_addr_i  in  NSTG x AW  stage destination address.
- stg_src_i  in  NSTG x 2  data source: 00 ALU, 01 DMEM, 11 IMM.
- stg_dt_i  in  NSTG x DW  stage result.
- ld_issue_i  in  1  issue a variable-latency load.
- ld_addr_i  in  AW  destination of the issued load.
- ld_rsp_i  in  1  load response (in-order); ld_rsp_dt_i  in  DW  response data.
- rd_dt_o  out  NPORT x DW  forwarded operand, registered.
- stall_o  out  1  hold the decode stage.
- ldq_full_o  out  1  load queue full.
- err_o  out  1  sticky protocol error.
- stall_cnt_o  out  16  saturating count of stall cycles.

Function
REQ-008 SHALL resolve each port p combinationally, in priority order:
- load-response hit (ld_rsp_i and queue head address == rs_addr_i[p]) -> ld_rsp_dt_i;
- otherwise the lowest-index stage s with stg_we_i[s] and stg_addr_i[s] == rs_addr_i[p] -> stg_dt_i[s];
- otherwise rs_dt_i[p].
REQ-009 SHALL raise a port stall when the matched stage s has src 01 and s < LD_STG.
REQ-010 SHALL raise a port stall when rs_addr_i[p] has its pending bit set and there is no response hit that cycle.
REQ-011 SHALL ignore ports with rs_re_i[p] = 0 for stall generation.
REQ-012 SHALL drive stall_o as the OR of all port stalls, combinationally, with zero-cycle latency.
REQ-013 SHALL register rd_dt_o one cycle after the address is presented, updated only when ~halt_i and ~stall_o; rd_dt_o SHALL hold its value otherwise.
REQ-014 SHALL keep the load queue as an in-order FIFO of AW-bit addresses, plus a 2^AW pending-bit vector.
REQ-015 SHALL, on ld_issue_i with the queue not full: push ld_addr_i and set its pending bit.
REQ-016 SHALL, on ld_issue_i with the queue full: drop the issue and set err_o.
REQ-017 SHALL, on ld_rsp_i with the queue non-empty: pop the head; it SHALL clear the head's pending bit only if no younger queue entry holds the same address.
REQ-018 SHALL, on ld_rsp_i with the queue empty: ignore the response and set err_o.
REQ-019 SHALL, on simultaneous issue and response: pop and push in the same cycle, legal even when the queue is full.
REQ-020 SHALL, on simultaneous issue and response to the same address: leave the pending bit set.
REQ-021 SHALL wrap the FIFO pointers modulo LDQ and use an extra pointer bit for full/empty detection.
REQ-022 SHALL assert ldq_full_o when the count equals LDQ.
REQ-023 SHALL, on flush_i: empty the queue, clear all pending bits, and leave err_o and the counter unchanged; flush takes priority over issue and response in the same cycle.
REQ-024 SHALL increment stall_cnt_o on each cycle with stall_o and ~halt_i, saturating at 0xFFFF.
REQ-025 SHALL, while halt_i is asserted: freeze the queue, the pending bits and the counter; issue and response SHALL be ignored.

Reset
REQ-026 SHALL, on rst_ni low: clear rd_dt_o to 0, empty the queue, clear the pending bits, and clear err_o and stall_cnt_o; ldq_full_o SHALL be 0.
REQ-027 SHALL leave stall_o combinational during reset (it follows the cleared state).
REQ-028 SHALL discard all outstanding loads on reset mid-operation.

Structure
REQ-029 SHALL take the source encodings (ALU, DMEM, IMM) and the stage struct type from the shared qick package.
REQ-030 SHALL implement the load queue as the sub-module qcore_ldq (FIFO plus same-address lookup).

Verification
REQ-031 SHALL cover ALU forwarding: stage 1 writes r5 = 0x11, stage 2 writes r5 = 0x22, port 0 reads r5 -> rd_dt_o[0] = 0x11 next cycle, no stall.
REQ-032 SHALL cover the DMEM hazard: stage 0 src 01 writing r3, port 1 reads r3 -> stall_o = 1 for that cycle; the next cycle, with the write at stage 1, -> forwarded, stall_o = 0.
REQ-033 SHALL cover the load scoreboard: issue a load to r9, read r9 for 3 cycles -> stall_o = 1 and stall_cnt_o = 3; then ld_rsp_i with data 0xABCD -> rd_dt_o = 0xABCD and r9 no longer pending.
REQ-034 SHALL cover queue overflow and underflow: 4 issues then a 5th -> ldq_full_o = 1, err_o = 1, 5th dropped; response with an empty queue -> err_o = 1.
REQ-035 SHALL cover duplicate addresses: two loads to r2, the first response -> r2 still pending; the second response -> cleared.
REQ-036 SHALL cover flush and reset: 2 loads pending then flush_i -> queue empty and no stall; assert rst_ni low mid-stall -> all outputs 0.

Source files
------------

// File: rtl/qick_pkg.sv
// Shared qick definitions: the data-source encodings and the per-stage control struct
// used by the operand-forwarding logic.
package qick_pkg;

   typedef enum logic [1:0] {
      SRC_ALU  = 2'b00,
      SRC_DMEM = 2'b01,
      SRC_IMM  = 2'b11
   } src_e;

   typedef struct packed {
      logic we;
      src_e src;
   } stg_ctl_t;

   localparam int CNT_W = 16;

endpackage

// File: rtl/qcore_fwd_scoreboard_if.sv
// Operand-read, pipeline-stage and load-queue signals of the forwarding scoreboard.
// The design side uses the slave modport.
interface qcore_fwd_scoreboard_if #(
   parameter int NPORT = 2,
   parameter int NSTG  = 3,
   parameter int AW    = 7,
   parameter int DW    = 32
);
   logic                            halt_i;
   logic                            flush_i;
   logic [NPORT-1:0]                rs_re_i;
   logic [NPORT-1:0][AW-1:0]        rs_addr_i;
   logic [NPORT-1:0][DW-1:0]        rs_dt_i;
   logic [NSTG-1:0]                 stg_we_i;
   logic [NSTG-1:0][AW-1:0]         stg_addr_i;
   logic [NSTG-1:0][1:0]            stg_src_i;
   logic [NSTG-1:0][DW-1:0]         stg_dt_i;
   logic                            ld_issue_i;
   logic [AW-1:0]                   ld_addr_i;
   logic                            ld_rsp_i;
   logic [DW-1:0]                   ld_rsp_dt_i;
   logic [NPORT-1:0][DW-1:0]        rd_dt_o;
   logic                            stall_o;
   logic                            ldq_full_o;
   logic                            err_o;
   logic [15:0]                     stall_cnt_o;

   modport slave (
      input  halt_i, flush_i, rs_re_i, rs_addr_i, rs_dt_i,
             stg_we_i, stg_addr_i, stg_src_i, stg_dt_i,
             ld_issue_i, ld_addr_i, ld_rsp_i, ld_rsp_dt_i,
      output rd_dt_o, stall_o, ldq_full_o, err_o, stall_cnt_o
   );

   modport master (
      output halt_i, flush_i, rs_re_i, rs_addr_i, rs_dt_i,
             stg_we_i, stg_addr_i, stg_src_i, stg_dt_i,
             ld_issue_i, ld_addr_i, ld_rsp_i, ld_rsp_dt_i,
      input  rd_dt_o, stall_o, ldq_full_o, err_o, stall_cnt_o
   );

endinterface

// File: rtl/qcore_ldq.sv
// In-order outstanding-load FIFO with a per-register pending vector; a pop keeps the
// pending bit when a younger entry still targets the same register.
module qcore_ldq #(
   parameter int AW  = 7,
   parameter int LDQ = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              flush_i,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [AW-1:0]     push_addr_i,
   output logic [AW-1:0]     head_addr_o,
   output logic              full_o,
   output logic              empty_o,
   output logic [2**AW-1:0]  pend_o
);
   localparam int PW = $clog2(LDQ);

   logic [PW:0]      wr_q, rd_q, cnt;
   logic [AW-1:0]    mem_q [LDQ];
   logic [2**AW-1:0] pend_q, pend_nxt;
   logic             dup;

   assign cnt         = wr_q - rd_q;
   assign empty_o     = (wr_q == rd_q);
   assign full_o      = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
   assign head_addr_o = mem_q[rd_q[PW-1:0]];
   assign pend_o      = pend_q;

   always_comb begin
      dup = 1'b0;
      for (int i = 1; i < LDQ; i++)
         if (i < int'(cnt) && mem_q[rd_q[PW-1:0] + PW'(i)] == head_addr_o)
            dup = 1'b1;
   end

   // Clear before set so a same-address pop/push leaves the bit set.
   always_comb begin
      pend_nxt = pend_q;
      if (pop_i && !dup) pend_nxt[head_addr_o] = 1'b0;
      if (push_i)        pend_nxt[push_addr_i] = 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q   <= '0;
         rd_q   <= '0;
         pend_q <= '0;
      end else if (flush_i) begin
         wr_q   <= '0;
         rd_q   <= '0;
         pend_q <= '0;
      end else begin
         if (pop_i)  rd_q <= rd_q + 1'b1;
         if (push_i) wr_q <= wr_q + 1'b1;
         pend_q <= pend_nxt;
      end
   end

   always_ff @(posedge clk_i)
      if (push_i) mem_q[wr_q[PW-1:0]] <= push_addr_i;

endmodule

// File: rtl/qcore_fwd_scoreboard.sv
// Operand forwarding with a load scoreboard: picks each read port's operand from the
// load response, the youngest writing stage or the register file, and stalls decode.
module qcore_fwd_scoreboard
   import qick_pkg::*;
#(
   parameter int NPORT  = 2,
   parameter int NSTG   = 3,
   parameter int AW     = 7,
   parameter int DW     = 32,
   parameter int LD_STG = 1,
   parameter int LDQ    = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   qcore_fwd_scoreboard_if.slave bus
);
   localparam int NREG = 2**AW;

   logic                     run, rsp_live, do_pop, do_push, q_flush, err_set;
   logic                     q_full, q_empty, stall;
   logic [AW-1:0]            head_addr;
   logic [NREG-1:0]          pend;
   logic [NPORT-1:0]         port_stall;
   logic [NPORT-1:0][DW-1:0] fwd, rd_q;
   logic                     err_q;
   logic [CNT_W-1:0]         cnt_q;
   stg_ctl_t                 ctl [NSTG];

   assign run      = ~bus.halt_i;
   assign rsp_live = bus.ld_rsp_i & ~q_empty;
   assign q_flush  = run & bus.flush_i;
   assign do_pop   = run & ~bus.flush_i & rsp_live;
   // A full queue still accepts an issue when the head leaves in the same cycle.
   assign do_push  = run & ~bus.flush_i & bus.ld_issue_i & (~q_full | rsp_live);
   assign err_set  = run & ~bus.flush_i &
                     ((bus.ld_issue_i & q_full & ~rsp_live) | (bus.ld_rsp_i & q_empty));

   qcore_ldq #(.AW(AW), .LDQ(LDQ)) u_ldq (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .flush_i     (q_flush),
      .push_i      (do_push),
      .pop_i       (do_pop),
      .push_addr_i (bus.ld_addr_i),
      .head_addr_o (head_addr),
      .full_o      (q_full),
      .empty_o     (q_empty),
      .pend_o      (pend)
   );

   for (genvar s = 0; s < NSTG; s++) begin : g_stg
      assign ctl[s] = '{we: bus.stg_we_i[s], src: src_e'(bus.stg_src_i[s])};
   end

   for (genvar p = 0; p < NPORT; p++) begin : g_port
      logic          rsp_hit, stg_hit, dmem_haz;
      logic [DW-1:0] stg_dt;

      // Descending scan: the last match written is the lowest (youngest) stage.
      always_comb begin
         rsp_hit  = rsp_live & (head_addr == bus.rs_addr_i[p]);
         stg_hit  = 1'b0;
         stg_dt   = '0;
         dmem_haz = 1'b0;
         for (int s = NSTG-1; s >= 0; s--) begin
            if (ctl[s].we && bus.stg_addr_i[s] == bus.rs_addr_i[p]) begin
               stg_hit  = 1'b1;
               stg_dt   = bus.stg_dt_i[s];
               dmem_haz = (ctl[s].src == SRC_DMEM) && (s < LD_STG);
            end
         end
      end

      assign fwd[p] = rsp_hit ? bus.ld_rsp_dt_i :
                      stg_hit ? stg_dt : bus.rs_dt_i[p];
      assign port_stall[p] = bus.rs_re_i[p] & ~rsp_hit &
                             ((stg_hit & dmem_haz) | pend[bus.rs_addr_i[p]]);
   end

   assign stall = |port_stall;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_q  <= '0;
         err_q <= 1'b0;
         cnt_q <= '0;
      end else if (run) begin
         if (!stall)                  rd_q  <= fwd;
         if (err_set)                 err_q <= 1'b1;
         if (stall && cnt_q != '1)    cnt_q <= cnt_q + 1'b1;
      end
   end

   assign bus.rd_dt_o     = rd_q;
   assign bus.stall_o     = stall;
   assign bus.ldq_full_o  = q_full;
   assign bus.err_o       = err_q;
   assign bus.stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_qcore_fwd_scoreboard.sv
// Bench for qcore_fwd_scoreboard: forwarding table, load-queue corner sequences and a
// random run against a queue-based reference model.
module tb_qcore_fwd_scoreboard;
   localparam int NPORT = 2, NSTG = 3, AW = 7, DW = 32, LD_STG = 1, LDQ = 4;

   logic clk_i = 1'b0;
   logic rst_ni = 1'b0;
   always #5 clk_i = ~clk_i;

   qcore_fwd_scoreboard_if #(.NPORT(NPORT), .NSTG(NSTG), .AW(AW), .DW(DW)) bus ();

   qcore_fwd_scoreboard #(
      .NPORT(NPORT), .NSTG(NSTG), .AW(AW), .DW(DW), .LD_STG(LD_STG), .LDQ(LDQ)
   ) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (bus)
   );

   int n_cmp = 0, n_bad = 0;

   // Reference state: outstanding loads as a plain address queue.
   int                       mq[$];
   logic [DW-1:0]            m_rd [NPORT];
   logic                     m_err;
   int                       m_cnt;
   logic [NPORT-1:0][DW-1:0] e_fwd;
   logic                     e_stall, s_stall;

   typedef struct {
      logic [1:0] re;
      logic [6:0] a0, a1;
      logic [2:0] we;
      logic [6:0] sa0, sa1, sa2;
      logic [1:0] sr0, sr1, sr2;
      logic       stall;
      logic [31:0] r0, r1;
   } vec_t;
   vec_t vt[8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic idle();
      bus.halt_i = 0; bus.flush_i = 0; bus.rs_re_i = '0; bus.rs_addr_i = '0;
      bus.rs_dt_i[0] = 32'h1000; bus.rs_dt_i[1] = 32'h2000;
      bus.stg_we_i = '0; bus.stg_addr_i = '0; bus.stg_src_i = '0;
      bus.stg_dt_i[0] = 32'hA0; bus.stg_dt_i[1] = 32'h11; bus.stg_dt_i[2] = 32'h22;
      bus.ld_issue_i = 0; bus.ld_addr_i = '0; bus.ld_rsp_i = 0; bus.ld_rsp_dt_i = '0;
   endtask

   task automatic model_comb();
      e_stall = 0;
      for (int p = 0; p < NPORT; p++) begin
         int a, sh;
         bit hit, pnd;
         a   = int'(bus.rs_addr_i[p]);
         sh  = -1;
         hit = bus.ld_rsp_i && mq.size() > 0 && mq[0] == a;
         pnd = 0;
         foreach (mq[i]) if (mq[i] == a) pnd = 1;
         for (int s = 0; s < NSTG; s++)
            if (sh < 0 && bus.stg_we_i[s] && int'(bus.stg_addr_i[s]) == a) sh = s;
         if (hit)          e_fwd[p] = bus.ld_rsp_dt_i;
         else if (sh >= 0) e_fwd[p] = bus.stg_dt_i[sh];
         else              e_fwd[p] = bus.rs_dt_i[p];
         if (bus.rs_re_i[p] && !hit &&
             (pnd || (sh >= 0 && sh < LD_STG && bus.stg_src_i[sh] == 2'b01)))
            e_stall = 1;
      end
   endtask

   task automatic model_edge();
      bit rsp_ok, iss_ok;
      if (bus.halt_i) return;
      if (!e_stall) for (int p = 0; p < NPORT; p++) m_rd[p] = e_fwd[p];
      if (e_stall && m_cnt < 65535) m_cnt++;
      if (bus.flush_i) begin
         mq.delete();
         return;
      end
      rsp_ok = bus.ld_rsp_i && mq.size() > 0;
      iss_ok = bus.ld_issue_i && (mq.size() < LDQ || rsp_ok);
      if (bus.ld_rsp_i && !rsp_ok)   m_err = 1;
      if (bus.ld_issue_i && !iss_ok) m_err = 1;
      if (rsp_ok) void'(mq.pop_front());
      if (iss_ok) mq.push_back(int'(bus.ld_addr_i));
   endtask

   // One cycle with inputs already driven: stall checked mid-cycle, state after the edge.
   task automatic rstep();
      @(negedge clk_i);
      model_comb();
      s_stall = bus.stall_o;
      chk("stall", s_stall, e_stall);
      @(posedge clk_i);
      model_edge();
      #1;
      for (int p = 0; p < NPORT; p++) chk("rd_dt", bus.rd_dt_o[p], m_rd[p]);
      chk("err", bus.err_o, m_err);
      chk("full", bus.ldq_full_o, mq.size() == LDQ);
      chk("stall_cnt", bus.stall_cnt_o, m_cnt);
   endtask

   task automatic do_reset();
      idle();
      rst_ni = 0;
      mq.delete();
      m_err = 0;
      m_cnt = 0;
      for (int p = 0; p < NPORT; p++) m_rd[p] = '0;
      repeat (2) @(posedge clk_i);
      #1 rst_ni = 1;
   endtask

   initial begin
      vt[0] = '{2'b01, 7'd5, 7'd0, 3'b110, 7'd0, 7'd5, 7'd5, 2'b00, 2'b00, 2'b00, 1'b0, 32'h11, 32'h2000};
      vt[1] = '{2'b10, 7'd5, 7'd3, 3'b001, 7'd3, 7'd0, 7'd0, 2'b01, 2'b00, 2'b00, 1'b1, 32'h11, 32'h2000};
      vt[2] = '{2'b10, 7'd5, 7'd3, 3'b010, 7'd0, 7'd3, 7'd0, 2'b00, 2'b01, 2'b00, 1'b0, 32'h1000, 32'h11};
      vt[3] = '{2'b00, 7'd5, 7'd3, 3'b001, 7'd3, 7'd0, 7'd0, 2'b01, 2'b00, 2'b00, 1'b0, 32'h1000, 32'hA0};
      vt[4] = '{2'b11, 7'd7, 7'd7, 3'b111, 7'd7, 7'd7, 7'd7, 2'b11, 2'b00, 2'b01, 1'b0, 32'hA0, 32'hA0};
      vt[5] = '{2'b11, 7'd1, 7'd2, 3'b000, 7'd1, 7'd2, 7'd0, 2'b00, 2'b00, 2'b00, 1'b0, 32'h1000, 32'h2000};
      vt[6] = '{2'b11, 7'd4, 7'd4, 3'b011, 7'd4, 7'd4, 7'd0, 2'b11, 2'b01, 2'b00, 1'b0, 32'hA0, 32'hA0};
      vt[7] = '{2'b01, 7'd6, 7'd0, 3'b001, 7'd6, 7'd0, 7'd0, 2'b01, 2'b00, 2'b00, 1'b1, 32'hA0, 32'hA0};

      idle();
      #1;
      chk("rst_rd0", bus.rd_dt_o[0], 0);
      chk("rst_full", bus.ldq_full_o, 0);
      chk("rst_err", bus.err_o, 0);
      chk("rst_cnt", bus.stall_cnt_o, 0);
      do_reset();

      // Forwarding table
      foreach (vt[i]) begin
         idle();
         bus.rs_re_i = vt[i].re; bus.rs_addr_i[0] = vt[i].a0; bus.rs_addr_i[1] = vt[i].a1;
         bus.stg_we_i = vt[i].we;
         bus.stg_addr_i[0] = vt[i].sa0; bus.stg_addr_i[1] = vt[i].sa1; bus.stg_addr_i[2] = vt[i].sa2;
         bus.stg_src_i[0] = vt[i].sr0; bus.stg_src_i[1] = vt[i].sr1; bus.stg_src_i[2] = vt[i].sr2;
         rstep();
         chk($sformatf("tbl%0d_stall", i), s_stall, vt[i].stall);
         chk($sformatf("tbl%0d_rd0", i), bus.rd_dt_o[0], vt[i].r0);
         chk($sformatf("tbl%0d_rd1", i), bus.rd_dt_o[1], vt[i].r1);
      end

      // Load scoreboard on r9
      do_reset();
      bus.ld_issue_i = 1; bus.ld_addr_i = 7'd9; rstep();
      bus.ld_issue_i = 0; bus.rs_re_i = 2'b01; bus.rs_addr_i[0] = 7'd9;
      repeat (3) begin rstep(); chk("ld_stall", s_stall, 1); end
      chk("ld_cnt3", bus.stall_cnt_o, 3);
      bus.ld_rsp_i = 1; bus.ld_rsp_dt_i = 32'hABCD; rstep();
      chk("rsp_nostall", s_stall, 0);
      chk("rsp_fwd", bus.rd_dt_o[0], 32'hABCD);
      bus.ld_rsp_i = 0; rstep();
      chk("r9_clear", s_stall, 0);
      chk("cnt_hold", bus.stall_cnt_o, 3);

      // Overflow, full-queue pop+push, underflow
      do_reset();
      for (int i = 1; i <= 4; i++) begin bus.ld_issue_i = 1; bus.ld_addr_i = 7'(i); rstep(); end
      chk("full4", bus.ldq_full_o, 1);
      chk("no_err4", bus.err_o, 0);
      bus.ld_addr_i = 7'd20; bus.ld_rsp_i = 1; rstep();
      chk("swap_full", bus.ldq_full_o, 1);
      chk("swap_noerr", bus.err_o, 0);
      bus.ld_rsp_i = 0; bus.ld_addr_i = 7'd21; rstep();
      chk("ovf_err", bus.err_o, 1);
      bus.ld_issue_i = 0; bus.rs_re_i = 2'b01; bus.rs_addr_i[0] = 7'd21; rstep();
      chk("ovf_dropped", s_stall, 0);
      bus.rs_addr_i[0] = 7'd20; rstep();
      chk("swap_pend", s_stall, 1);
      bus.rs_re_i = '0; bus.ld_rsp_i = 1; repeat (4) rstep();
      chk("drained", bus.ldq_full_o, 0);
      do_reset();
      bus.ld_rsp_i = 1; rstep();
      chk("udf_err", bus.err_o, 1);

      // Duplicate addresses, and same-address issue with response
      do_reset();
      bus.ld_issue_i = 1; bus.ld_addr_i = 7'd2; rstep(); rstep();
      bus.ld_issue_i = 0; bus.ld_rsp_i = 1; rstep();
      bus.ld_rsp_i = 0; bus.rs_re_i = 2'b01; bus.rs_addr_i[0] = 7'd2; rstep();
      chk("dup_pend", s_stall, 1);
      bus.ld_rsp_i = 1; rstep();
      bus.ld_rsp_i = 0; rstep();
      chk("dup_clear", s_stall, 0);
      bus.rs_re_i = '0; bus.ld_issue_i = 1; bus.ld_addr_i = 7'd8; rstep();
      bus.ld_rsp_i = 1; rstep();
      bus.ld_issue_i = 0; bus.ld_rsp_i = 0; bus.rs_re_i = 2'b10; bus.rs_addr_i[1] = 7'd8; rstep();
      chk("same_addr_pend", s_stall, 1);

      // Flush, then reset mid-stall
      do_reset();
      bus.ld_issue_i = 1; bus.ld_addr_i = 7'd10; rstep();
      bus.ld_addr_i = 7'd11; rstep();
      bus.ld_issue_i = 0; bus.rs_re_i = 2'b01; bus.rs_addr_i[0] = 7'd10; rstep();
      chk("pre_flush_stall", s_stall, 1);
      bus.flush_i = 1; rstep();
      bus.flush_i = 0; rstep();
      chk("flush_nostall", s_stall, 0);
      bus.rs_re_i = '0; bus.ld_rsp_i = 1; rstep();
      chk("flush_empty", bus.err_o, 1);
      bus.ld_rsp_i = 0; bus.ld_issue_i = 1; bus.ld_addr_i = 7'd12; rstep();
      bus.ld_issue_i = 0; bus.rs_re_i = 2'b01; bus.rs_addr_i[0] = 7'd12; rstep();
      chk("pre_rst_stall", s_stall, 1);
      #2 rst_ni = 0;
      #1;
      chk("mid_rst_rd0", bus.rd_dt_o[0], 0);
      chk("mid_rst_stall", bus.stall_o, 0);
      chk("mid_rst_full", bus.ldq_full_o, 0);
      chk("mid_rst_err", bus.err_o, 0);
      chk("mid_rst_cnt", bus.stall_cnt_o, 0);
      do_reset();

      // Random traffic against the model
      for (int n = 0; n < 800; n++) begin
         bus.halt_i     = ($urandom_range(0, 9) == 0);
         bus.flush_i    = ($urandom_range(0, 29) == 0);
         bus.rs_re_i    = 2'($urandom_range(0, 3));
         for (int p = 0; p < NPORT; p++) begin
            bus.rs_addr_i[p] = 7'($urandom_range(0, 7));
            bus.rs_dt_i[p]   = $urandom;
         end
         for (int s = 0; s < NSTG; s++) begin
            int sr;
            sr = $urandom_range(0, 2);
            bus.stg_we_i[s]   = ($urandom_range(0, 2) == 0);
            bus.stg_addr_i[s] = 7'($urandom_range(0, 7));
            bus.stg_src_i[s]  = (sr == 2) ? 2'b11 : 2'(sr);
            bus.stg_dt_i[s]   = $urandom;
         end
         bus.ld_issue_i  = ($urandom_range(0, 2) == 0);
         bus.ld_addr_i   = 7'($urandom_range(0, 7));
         bus.ld_rsp_i    = ($urandom_range(0, 2) == 0);
         bus.ld_rsp_dt_i = $urandom;
         rstep();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
